// File: rtl/axi_rd_arbiter_if.sv
// rtl/axi_rd_arbiter_if.sv - AXI read-address and read-data channel bundle for axi_rd_arbiter
interface axi_rd_arbiter_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-requester AXI read arbiter with 256-bit line assembly; RD_ARB_ROUND_ROBIN_EN selects round-robin arbitration
module axi_rd_arbiter (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  flush,
  input  logic                  ird_req,
  input  logic [31:0]           ird_addr,
  input  logic [7:0]            ird_len,
  output logic                  ird_valid,
  output logic [255:0]          ird_data,
  input  logic                  drd_req,
  input  logic [31:0]           drd_addr,
  input  logic [7:0]            drd_len,
  input  logic [2:0]            drd_arsize,
  output logic                  drd_valid,
  output logic [255:0]          drd_data,
  axi_rd_arbiter_if.master      axi
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] RET  = 2'd3;

  logic [1:0]   state;
  logic         owner;      // 0 = instruction, 1 = data; doubles as arid
  logic [31:0]  addr_q;
  logic [7:0]   len_q;
  logic [2:0]   size_q;
  logic [2:0]   cnt;
  logic         flushed;    // instruction burst already on the bus when flush arrived
  logic [255:0] line;
  logic [255:0] line_nxt;
  logic         i_req;
  logic         pick_data;
  logic         beat_ok;
  logic         last_ok;

  // A flushed instruction request is never granted, so data can still win that cycle
  assign i_req = ird_req && !flush;

`ifdef RD_ARB_ROUND_ROBIN_EN
  logic last_data;

  // On a tie, the requester not served last wins; starts as "data served last"
  assign pick_data = drd_req && (!i_req || !last_data);

  // Remember which requester was granted most recently
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      last_data <= 1'b1;
    end else if (state == IDLE && (i_req || drd_req)) begin
      last_data <= pick_data;
    end
  end
`else
  assign pick_data = drd_req;
`endif

  // Only beats carrying the owner's id land in the line; foreign ids are drained
  assign beat_ok = (state == DATA) && axi.rvalid && (axi.rid == {3'b000, owner});
  assign last_ok = beat_ok && axi.rlast;

  assign axi.arvalid = (state == ADDR);
  assign axi.rready  = (state == DATA);
  assign axi.arid    = {3'b000, owner};
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = 2'b01;

  // Line with the current beat merged in; untouched words keep old contents
  always_comb begin
    line_nxt = line;
    if (beat_ok) begin
      line_nxt[{cnt, 5'd0} +: 32] = axi.rdata;
    end
  end

  // Transaction FSM, line assembly and return pulses
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      owner     <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      cnt       <= '0;
      flushed   <= 1'b0;
      line      <= '0;
      ird_valid <= 1'b0;
      drd_valid <= 1'b0;
      ird_data  <= '0;
      drd_data  <= '0;
    end else begin
      ird_valid <= 1'b0;
      drd_valid <= 1'b0;
      line      <= line_nxt;
      case (state)
        IDLE: begin
          if (i_req || drd_req) begin
            owner   <= pick_data;
            addr_q  <= pick_data ? drd_addr : ird_addr;
            len_q   <= pick_data ? drd_len : ird_len;
            size_q  <= pick_data ? drd_arsize : 3'b010;
            cnt     <= '0;
            flushed <= 1'b0;
            state   <= ADDR;
          end
        end
        ADDR: begin
          // A handshake in the same cycle as flush wins: the slave has the AR
          if (axi.arready) begin
            state <= DATA;
          end else if (flush && !owner) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (flush && !owner) begin
            flushed <= 1'b1;
          end
          if (beat_ok) begin
            cnt <= cnt + 3'd1;
          end
          // The return pulse is raised on entry to RET so it is high for exactly the RET cycle
          if (last_ok) begin
            state <= RET;
            if (owner) begin
              drd_valid <= 1'b1;
              drd_data  <= line_nxt;
            end else if (!(flushed || flush)) begin
              ird_valid <= 1'b1;
              ird_data  <= line_nxt;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - scoreboard bench for axi_rd_arbiter with a simple AXI read slave
module tb_axi_rd_arbiter;
  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic         flush = 1'b0;
  logic         ird_req = 1'b0;
  logic [31:0]  ird_addr = '0;
  logic [7:0]   ird_len = '0;
  logic         ird_valid;
  logic [255:0] ird_data;
  logic         drd_req = 1'b0;
  logic [31:0]  drd_addr = '0;
  logic [7:0]   drd_len = '0;
  logic [2:0]   drd_arsize = '0;
  logic         drd_valid;
  logic [255:0] drd_data;

  axi_rd_arbiter_if axi ();

  axi_rd_arbiter dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .flush      (flush),
    .ird_req    (ird_req),
    .ird_addr   (ird_addr),
    .ird_len    (ird_len),
    .ird_valid  (ird_valid),
    .ird_data   (ird_data),
    .drd_req    (drd_req),
    .drd_addr   (drd_addr),
    .drd_len    (drd_len),
    .drd_arsize (drd_arsize),
    .drd_valid  (drd_valid),
    .drd_data   (drd_data),
    .axi        (axi)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  // Slave controls, written by the test tasks
  logic        ar_ready_drv = 1'b1;
  logic [31:0] base_i = '0;
  logic [31:0] base_d = '0;
  logic        inject_bad = 1'b0;
  logic        slave_kill = 1'b0;

  assign axi.arready = ar_ready_drv;

  // Slave state and AR log, written only by the slave process
  int          ar_n = 0;
  logic [3:0]  ar_id_log   [0:15];
  logic [31:0] ar_addr_log [0:15];
  logic [7:0]  ar_len_log  [0:15];
  logic [2:0]  ar_size_log [0:15];
  int          ar_cyc_log  [0:15];
  int          beats_left = 0;
  int          beat_idx = 0;
  int          beats_done = 0;
  logic        bad_pending = 1'b0;
  logic [3:0]  cur_id = '0;
  logic [31:0] cur_base = '0;

  // AXI slave: beats start the cycle after the AR handshake, back to back
  always @(negedge aclk) begin
    if (slave_kill) begin
      beats_left  = 0;
      bad_pending = 1'b0;
    end
    if (beats_left > 0 && bad_pending && beat_idx == 2) begin
      axi.rvalid  = 1'b1;
      axi.rid     = cur_id ^ 4'd1;
      axi.rdata   = 32'hDEAD_BEEF;
      axi.rlast   = 1'b0;
      bad_pending = 1'b0;
    end else if (beats_left > 0) begin
      axi.rvalid = 1'b1;
      axi.rid    = cur_id;
      axi.rdata  = cur_base + 32'(beat_idx);
      axi.rlast  = (beats_left == 1);
      beat_idx++;
      beats_left--;
      beats_done++;
    end else begin
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rid    = '0;
      axi.rdata  = '0;
    end
    if (axi.arvalid && axi.arready) begin
      ar_id_log[ar_n % 16]   = axi.arid;
      ar_addr_log[ar_n % 16] = axi.araddr;
      ar_len_log[ar_n % 16]  = axi.arlen;
      ar_size_log[ar_n % 16] = axi.arsize;
      ar_cyc_log[ar_n % 16]  = cyc;
      ar_n++;
      cur_id      = axi.arid;
      cur_base    = (axi.arid == 4'd0) ? base_i : base_d;
      beats_left  = int'(axi.arlen) + 1;
      beat_idx    = 0;
      bad_pending = inject_bad;
    end
  end

  logic [255:0] iq[$];
  logic [255:0] dq[$];
  logic [255:0] model_line = '0;
  logic [255:0] last_ird = '0;

  function automatic logic [255:0] burst_line(input logic [255:0] prev, input logic [31:0] base, input int beats);
    logic [255:0] l = prev;
    for (int k = 0; k < beats; k++) l[(k % 8) * 32 +: 32] = base + 32'(k);
    return l;
  endfunction

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0; ird_req = 1'b0; drd_req = 1'b0; flush = 1'b0; slave_kill = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1; slave_kill = 1'b0;
    model_line = '0;
    last_ird = '0;
  endtask

  // Drains the scoreboard until all raised requests have been answered
  task automatic serve(input int budget, output int cv_i, output int cv_d);
    int n = 0;
    logic [255:0] exp_line;
    cv_i = -1; cv_d = -1;
    while ((ird_req || drd_req) && n < budget) begin
      @(negedge aclk);
      n++;
      if (ird_valid) begin
        compared++;
        if (iq.size() == 0) begin
          mismatched++;
          $display("FAIL ird_unexpected: ird_valid=1 at cycle %0d, required no pulse", cyc);
        end else begin
          exp_line = iq.pop_front();
          if (ird_data !== exp_line) begin
            mismatched++;
            $display("FAIL ird_data: got %h required %h", ird_data, exp_line);
          end
        end
        cv_i = cyc; ird_req = 1'b0;
      end
      if (drd_valid) begin
        compared++;
        if (dq.size() == 0) begin
          mismatched++;
          $display("FAIL drd_unexpected: drd_valid=1 at cycle %0d, required no pulse", cyc);
        end else begin
          exp_line = dq.pop_front();
          if (drd_data !== exp_line) begin
            mismatched++;
            $display("FAIL drd_data: got %h required %h", drd_data, exp_line);
          end
        end
        cv_d = cyc; drd_req = 1'b0;
      end
    end
    compared++;
    if (ird_req || drd_req) begin
      mismatched++;
      $display("FAIL serve_timeout: ird_req=%0b drd_req=%0b still waiting after %0d cycles, required 0", ird_req, drd_req, budget);
      ird_req = 1'b0; drd_req = 1'b0;
      iq.delete(); dq.delete();
    end
    @(negedge aclk);
    compared++;
    if (ird_valid !== 1'b0 || drd_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL pulse_width: ird_valid=%0b drd_valid=%0b one cycle after pulse, required 0/0", ird_valid, drd_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge aclk);
    compared++;
    if ({axi.arvalid, axi.rready, ird_valid, drd_valid, axi.araddr, axi.arlen, axi.arsize, axi.arid} !== '0) begin
      mismatched++;
      $display("FAIL reset_ctrl: arvalid=%0b rready=%0b ird_valid=%0b drd_valid=%0b araddr=%h arlen=%h arsize=%h arid=%h, required all 0",
               axi.arvalid, axi.rready, ird_valid, drd_valid, axi.araddr, axi.arlen, axi.arsize, axi.arid);
    end
    compared++;
    if (ird_data !== '0 || drd_data !== '0) begin
      mismatched++;
      $display("FAIL reset_data: ird_data=%h drd_data=%h, required 0", ird_data, drd_data);
    end
    compared++;
    if (axi.arburst !== 2'b01) begin
      mismatched++;
      $display("FAIL arburst: got %b required 01", axi.arburst);
    end
  endtask

  task automatic test_single_instr();
    int c0, a0, cvi, cvd;
    base_i = 32'h0; ar_ready_drv = 1'b1;
    @(posedge aclk); #1;
    ird_addr = 32'h1FC0_0000; ird_len = 8'd7; ird_req = 1'b1;
    c0 = cyc; a0 = ar_n;
    model_line = burst_line(model_line, base_i, 8);
    iq.push_back(model_line); last_ird = model_line;
    serve(40, cvi, cvd);
    compared++;
    if (ar_n - a0 !== 1 || ar_id_log[a0 % 16] !== 4'd0 || ar_len_log[a0 % 16] !== 8'd7 ||
        ar_addr_log[a0 % 16] !== 32'h1FC0_0000 || ar_size_log[a0 % 16] !== 3'b010) begin
      mismatched++;
      $display("FAIL single_ar: n=%0d id=%h len=%h addr=%h size=%b, required 1/0/07/1fc00000/010",
               ar_n - a0, ar_id_log[a0 % 16], ar_len_log[a0 % 16], ar_addr_log[a0 % 16], ar_size_log[a0 % 16]);
    end
    compared++;
    if (cvi - c0 + 1 !== 11) begin
      mismatched++;
      $display("FAIL single_latency: got %0d cycles required 11", cvi - c0 + 1);
    end
  endtask

  task automatic test_flush();
    int a0, b0, pulses;
    // Abort in ADDR with the slave stalling
    ar_ready_drv = 1'b0;
    @(posedge aclk); #1;
    ird_addr = 32'h0000_0040; ird_len = 8'd7; ird_req = 1'b1;
    a0 = ar_n;
    @(posedge aclk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      compared++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h40 || axi.arid !== 4'd0 || axi.arsize !== 3'b010 || axi.arlen !== 8'd7) begin
        mismatched++;
        $display("FAIL addr_hold: arvalid=%0b araddr=%h arid=%h arsize=%b arlen=%h, required 1/00000040/0/010/07",
                 axi.arvalid, axi.araddr, axi.arid, axi.arsize, axi.arlen);
      end
      @(posedge aclk); #1;
    end
    flush = 1'b1; ird_req = 1'b0;
    @(posedge aclk); #1;
    flush = 1'b0;
    @(negedge aclk);
    compared++;
    if (axi.arvalid !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_addr_abort: arvalid=%0b required 0", axi.arvalid);
    end
    @(posedge aclk); #1;
    ar_ready_drv = 1'b1;
    repeat (3) @(negedge aclk);
    compared++;
    if (ar_n !== a0) begin
      mismatched++;
      $display("FAIL flush_no_ar: %0d handshakes, required 0", ar_n - a0);
    end

    // Flush one cycle after the handshake: burst drains, no pulse
    base_i = 32'h0000_0500;
    @(posedge aclk); #1;
    ird_req = 1'b1; a0 = ar_n; b0 = beats_done;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    flush = 1'b1; ird_req = 1'b0;
    @(posedge aclk); #1;
    flush = 1'b0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge aclk);
      if (ird_valid) pulses++;
    end
    model_line = burst_line(model_line, base_i, 8);
    compared++;
    if (pulses !== 0) begin
      mismatched++;
      $display("FAIL flush_suppress: ird_valid high %0d cycles, required 0", pulses);
    end
    compared++;
    if (ar_n - a0 !== 1 || beats_done - b0 !== 8) begin
      mismatched++;
      $display("FAIL flush_drain: %0d AR, %0d beats, required 1 AR, 8 beats", ar_n - a0, beats_done - b0);
    end
    compared++;
    if (ird_data !== last_ird || axi.rready !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_hold: ird_data=%h rready=%0b, required %h and 0", ird_data, axi.rready, last_ird);
    end
  endtask

  task automatic test_partial_beat();
    int c0, a0, cvi, cvd;
    base_d = 32'h0000_00A5;
    @(posedge aclk); #1;
    drd_addr = 32'h0000_2000; drd_len = 8'd0; drd_arsize = 3'b000; drd_req = 1'b1;
    c0 = cyc; a0 = ar_n;
    model_line = burst_line(model_line, base_d, 1);
    dq.push_back(model_line);
    serve(20, cvi, cvd);
    compared++;
    if (cvd - c0 + 1 !== 4) begin
      mismatched++;
      $display("FAIL partial_latency: got %0d cycles required 4", cvd - c0 + 1);
    end
    compared++;
    if (ar_id_log[a0 % 16] !== 4'd1 || ar_len_log[a0 % 16] !== 8'd0 || ar_size_log[a0 % 16] !== 3'b000) begin
      mismatched++;
      $display("FAIL partial_ar: id=%h len=%h size=%b, required 1/00/000", ar_id_log[a0 % 16], ar_len_log[a0 % 16], ar_size_log[a0 % 16]);
    end
  endtask

  task automatic test_wrap_foreign_id();
    int cvi, cvd;
    base_d = 32'h0000_0100; inject_bad = 1'b1;
    @(posedge aclk); #1;
    drd_addr = 32'h0000_3000; drd_len = 8'd9; drd_arsize = 3'b010; drd_req = 1'b1; flush = 1'b1;
    model_line = burst_line(model_line, base_d, 10);
    dq.push_back(model_line);
    serve(40, cvi, cvd);
    flush = 1'b0; inject_bad = 1'b0;
    compared++;
    if (cvd < 0) begin
      mismatched++;
      $display("FAIL data_ignores_flush: drd_valid never seen, required one pulse");
    end
  endtask

  task automatic test_arbitration();
    int a0, cvi, cvd, first_cv;
    logic [3:0] exp_first;
    logic [255:0] li, ld;
`ifdef RD_ARB_ROUND_ROBIN_EN
    exp_first = 4'd0;
`else
    exp_first = 4'd1;
`endif
    do_reset();
    a0 = ar_n;
    for (int r = 0; r < 2; r++) begin
      base_i = 32'h0000_1000 + 32'(r * 16);
      base_d = 32'h0000_2000 + 32'(r * 16);
      li = burst_line(model_line, base_i, 8);
      ld = burst_line(model_line, base_d, 8);
      @(posedge aclk); #1;
      ird_addr = 32'h0000_0100 + 32'(r * 32); ird_len = 8'd7;
      drd_addr = 32'h8000_0000 + 32'(r * 32); drd_len = 8'd7; drd_arsize = 3'b011;
      ird_req = 1'b1; drd_req = 1'b1;
      iq.push_back(li); dq.push_back(ld);
      serve(60, cvi, cvd);
      first_cv = (exp_first == 4'd1) ? cvd : cvi;
      compared++;
      if (ar_id_log[(a0 + 2 * r) % 16] !== exp_first || ar_id_log[(a0 + 2 * r + 1) % 16] !== (exp_first ^ 4'd1)) begin
        mismatched++;
        $display("FAIL arb_order round %0d: ids %h,%h required %h,%h", r,
                 ar_id_log[(a0 + 2 * r) % 16], ar_id_log[(a0 + 2 * r + 1) % 16], exp_first, exp_first ^ 4'd1);
      end
      compared++;
      if (!(ar_cyc_log[(a0 + 2 * r + 1) % 16] > first_cv)) begin
        mismatched++;
        $display("FAIL arb_single_outstanding round %0d: second AR at cycle %0d, required after cycle %0d", r,
                 ar_cyc_log[(a0 + 2 * r + 1) % 16], first_cv);
      end
      model_line = (exp_first == 4'd1) ? li : ld;
      last_ird = li;
    end
    compared++;
    if (ar_n - a0 !== 4 || ar_size_log[(a0 + ((exp_first == 4'd1) ? 0 : 1)) % 16] !== 3'b011) begin
      mismatched++;
      $display("FAIL arb_count: %0d AR, data arsize %b, required 4 AR and 011", ar_n - a0,
               ar_size_log[(a0 + ((exp_first == 4'd1) ? 0 : 1)) % 16]);
    end
  endtask

  task automatic test_reset_midburst();
    int b0, n, c0, cvi, cvd;
    base_i = 32'h0000_0900;
    @(posedge aclk); #1;
    ird_addr = 32'h0000_0800; ird_len = 8'd7; ird_req = 1'b1;
    b0 = beats_done; n = 0;
    while (beats_done - b0 < 3 && n < 30) begin
      @(negedge aclk);
      n++;
    end
    compared++;
    if (beats_done - b0 < 3) begin
      mismatched++;
      $display("FAIL midburst_timeout: %0d beats seen, required 3", beats_done - b0);
    end
    @(posedge aclk); #1;
    aresetn = 1'b0; slave_kill = 1'b1; ird_req = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    compared++;
    if ({axi.arvalid, axi.rready, ird_valid, drd_valid, axi.araddr, axi.arlen, axi.arsize, axi.arid} !== '0) begin
      mismatched++;
      $display("FAIL midburst_reset_ctrl: arvalid=%0b rready=%0b ird_valid=%0b drd_valid=%0b araddr=%h arlen=%h arsize=%h arid=%h, required all 0",
               axi.arvalid, axi.rready, ird_valid, drd_valid, axi.araddr, axi.arlen, axi.arsize, axi.arid);
    end
    compared++;
    if (ird_data !== '0 || drd_data !== '0) begin
      mismatched++;
      $display("FAIL midburst_reset_data: ird_data=%h drd_data=%h, required 0", ird_data, drd_data);
    end
    @(posedge aclk); #1;
    slave_kill = 1'b0;
    model_line = '0;
    base_i = 32'h0000_0040;
    @(posedge aclk); #1;
    ird_addr = 32'h0000_0C00; ird_len = 8'd7; ird_req = 1'b1;
    c0 = cyc;
    model_line = burst_line(model_line, base_i, 8);
    iq.push_back(model_line);
    serve(40, cvi, cvd);
    compared++;
    if (cvi - c0 + 1 !== 11) begin
      mismatched++;
      $display("FAIL post_reset_latency: got %0d cycles required 11", cvi - c0 + 1);
    end
  endtask

  initial begin
    test_reset();
    test_single_instr();
    test_flush();
    test_partial_beat();
    test_wrap_foreign_id();
    test_arbitration();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
